// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a fixed DATA_WIDTH+1 cycle start-to-done latency.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t        state;
  logic [2:0]    op;
  logic [W-1:0]  operand_mag;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [CW-1:0] count;
  logic          sign_flag;
  logic          rem_sign;
  logic          special;
  logic [W-1:0]  special_val;

  logic          a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]  a_mag, b_mag, special_calc;

  // Operand conditioning, consumed only on the edge that accepts a start.
  always_comb begin
    a_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    a_neg    = a_signed && operand_a_i[W-1];
    b_neg    = b_signed && operand_b_i[W-1];
    a_mag    = a_neg ? -operand_a_i : operand_a_i;
    b_mag    = b_neg ? -operand_b_i : operand_b_i;
    div_zero = op_i[2] && (operand_b_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (operand_a_i == MOST_NEG) && (operand_b_i == '1);
    if (div_zero) begin
      special_calc = op_i[1] ? operand_a_i : '1;
    end else begin
      special_calc = op_i[1] ? '0 : MOST_NEG;
    end
  end

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   hi_next, lo_next;
  logic [2*W-1:0] product, product_signed;
  logic [W-1:0]   quotient, remainder, final_result;

  // hi/lo hold the product halves for multiply, remainder/quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand_mag} : '0);
    div_shift = {hi, lo[W-1]};
    div_ge    = div_shift >= {1'b0, operand_mag};
    if (op[2]) begin
      hi_next = div_ge ? (div_shift[W-1:0] - operand_mag) : div_shift[W-1:0];
      lo_next = {lo[W-2:0], div_ge};
    end else begin
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo[W-1:1]};
    end
    product        = {hi_next, lo_next};
    product_signed = sign_flag ? -product : product;
    quotient       = sign_flag ? -lo_next : lo_next;
    remainder      = rem_sign ? -hi_next : hi_next;
    if (special) begin
      final_result = special_val;
    end else if (op[2]) begin
      final_result = op[1] ? remainder : quotient;
    end else if (op[1:0] == 2'b00) begin
      final_result = product_signed[W-1:0];
    end else begin
      final_result = product_signed[2*W-1:W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= '0;
      op          <= '0;
      operand_mag <= '0;
      hi          <= '0;
      lo          <= '0;
      count       <= '0;
      sign_flag   <= 1'b0;
      rem_sign    <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          done_o <= 1'b0;
          if (start_i) begin
            state       <= CALC;
            busy_o      <= 1'b1;
            op          <= op_i;
            count       <= CW'(W);
            hi          <= '0;
            lo          <= op_i[2] ? a_mag : b_mag;
            operand_mag <= op_i[2] ? b_mag : a_mag;
            sign_flag   <= a_neg ^ b_neg;
            rem_sign    <= a_neg;
            special     <= div_zero || div_ovf;
            special_val <= special_calc;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          hi <= hi_next;
          lo <= lo_next;
          if (count == CW'(1)) begin
            state    <= FINISH;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= final_result;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake corner
// sequences and randomized operations checked against an arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LATENCY = 33;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [2:0]    op_i;
  logic [W-1:0]  operand_a_i;
  logic [W-1:0]  operand_b_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  result_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Reference: RV32M semantics straight from wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    int ia, ib;
    logic ovf;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (op)
      3'd0: begin p = ua * ub; model = p[31:0];  end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: if (b == 0) model = 32'hFFFF_FFFF; else if (ovf) model = 32'h8000_0000; else model = ia / ib;
      3'd5: if (b == 0) model = 32'hFFFF_FFFF; else model = a / b;
      3'd6: if (b == 0) model = a; else if (ovf) model = 32'h0; else model = ia % ib;
      default: if (b == 0) model = a; else model = a % b;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one op and returns when done_o is seen (or after a bounded wait).
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat, output int busy_bad);
    start_i     = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    lat      = 1;
    busy_bad = 0;
    while (!done_o && lat < 100) begin
      if (busy_o !== 1'b1) busy_bad++;
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
  endtask

  task automatic run_and_check(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat, busy_bad;
    apply_stimulus(op, a, b, res, lat, busy_bad);
    check_output({name, "_result"}, res, exp);
    check_output({name, "_latency"}, 32'(lat), 32'(LATENCY));
    check_output({name, "_busy_calc"}, 32'(busy_bad), 32'd0);
    check_output({name, "_busy_finish"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int lat, pulses;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
    vecs[8]  = '{3'd5, 32'd123,        32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[12] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[13] = '{3'd0, 32'h8000_0000,  32'd2,          32'h0000_0000};
    vecs[14] = '{3'd4, 32'd0,          32'd0,          32'hFFFF_FFFF};
    vecs[15] = '{3'd7, 32'd7,          32'd0,          32'd7};
    vecs[16] = '{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[17] = '{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1};

    rst_i       = 1'b1;
    start_i     = 1'b0;
    op_i        = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_output("reset_busy", {31'b0, busy_o}, 32'd0);
    check_output("reset_done", {31'b0, done_o}, 32'd0);
    check_output("reset_result", result_o, 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      @(posedge clk_i); #1;
      check_output($sformatf("vec%0d_done_pulse", i), {31'b0, done_o}, 32'd0);
      check_output($sformatf("vec%0d_hold", i), result_o, vecs[i].exp);
    end

    // start_i held high through CALC with different operands must be ignored.
    start_i = 1'b1; op_i = 3'd0; operand_a_i = 32'd3; operand_b_i = 32'd5;
    @(posedge clk_i); #1;
    op_i = 3'd1; operand_a_i = 32'd9; operand_b_i = 32'd9;
    lat = 1;
    while (!done_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check_output("ignore_latency", 32'(lat), 32'(LATENCY));
    check_output("ignore_result", result_o, 32'd15);
    // New start accepted during the FINISH cycle.
    op_i = 3'd0; operand_a_i = 32'd2; operand_b_i = 32'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check_output("b2b_busy", {31'b0, busy_o}, 32'd1);
    check_output("b2b_done_low", {31'b0, done_o}, 32'd0);
    lat = 1;
    while (!done_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check_output("b2b_latency", 32'(lat), 32'(LATENCY));
    check_output("b2b_result", result_o, 32'd4);

    // Reset ten cycles into a divide aborts it without a done pulse.
    start_i = 1'b1; op_i = 3'd4; operand_a_i = 32'hFFFF_FF9C; operand_b_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_output("abort_busy", {31'b0, busy_o}, 32'd0);
    check_output("abort_done", {31'b0, done_o}, 32'd0);
    check_output("abort_result", result_o, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o) pulses++;
    end
    check_output("abort_no_done", 32'(pulses), 32'd0);
    run_and_check("after_abort_divu", 3'd5, 32'd9, 32'd3, 32'd3);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_and_check($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle execution unit for the RV32M instructions MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It sits in the execute stage beside the single-cycle ALU. It receives the same rs1/rs2 operands plus the instruction's funct3, and returns a result through a start/busy/done handshake. The pipeline control stalls on busy_o and writes back result_o when done_o pulses.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  request; sampled only when unit is not busy
op_i  input  3  funct3 opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  input  DATA_WIDTH  rs1 (multiplicand / dividend)
operand_b_i  input  DATA_WIDTH  rs2 (multiplier / divisor)
busy_o  output  1  high while an operation is in progress
done_o  output  1  one-cycle pulse: result_o valid
result_o  output  DATA_WIDTH  result; held stable until next accepted start

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE; busy_o=0, done_o=0, result_o=0; internal counter/accumulators cleared. Reset mid-operation aborts it with no done_o pulse.
- FSM states: IDLE, CALC, FINISH.
  - IDLE/FINISH + start_i=1 -> CALC. At this edge the unit latches op_i and both operands and loads counter = DATA_WIDTH.
  - IDLE/FINISH + start_i=0 -> IDLE.
  - CALC, counter != 1 -> CALC, counter decrements.
  - CALC, counter == 1 -> FINISH. result_o is written at this edge.
  - FINISH lasts exactly one cycle. done_o=1 in FINISH only.
- busy_o = 1 exactly in CALC. start_i during CALC is ignored; operands are not re-sampled.
- Back-to-back: start_i=1 during the FINISH cycle is accepted. done_o pulses for the old result while CALC begins for the new one.
- Latency is fixed for every op, including special cases. If start is accepted at edge N, done_o is high in the cycle after edge N+DATA_WIDTH (33 cycles for DATA_WIDTH=32).
- Sign preprocessing at the start edge:
  - MULH, DIV, REM: both operands are signed.
  - MULHSU: a signed, b unsigned.
  - Other ops: both unsigned.
  - The unit stores magnitudes and a result-sign flag.
  - For REM, the result sign is the dividend sign.
- Multiply: shift-add, one multiplier bit per CALC cycle, into a 2*DATA_WIDTH product. Negate the full product if the sign flag is set.
  - MUL returns product[DATA_WIDTH-1:0].
  - MULH/MULHSU/MULHU return product[2*DATA_WIDTH-1:DATA_WIDTH].
- Divide: restoring division, one quotient bit per CALC cycle. Quotient and remainder are negated per their sign flags at the final edge.
- Divide by zero:
  - DIV/DIVU return all ones.
  - REM/REMU return operand_a_i unchanged (signed value, not magnitude).
- Signed overflow, DIV of the most-negative value by -1: DIV returns the most-negative value (0x80000000); REM returns 0.
- Special cases are detected at the start edge and override the iterative result at the final edge. Latency is unchanged.
- All arithmetic wraps modulo 2^DATA_WIDTH (or 2^(2*DATA_WIDTH) for the product). No exceptions or flags are raised.

Test Plan:
- Reset, then MUL a=7 b=6 at edge 0 -> busy_o=1 for cycles 1..32; done_o=1 only in cycle 33; result_o=42; busy_o=0 after.
- MULH a=0xFFFFFFFF (-1) b=0xFFFFFFFF (-1) -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU a=-1 b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7 b=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU a=100 b=7 -> 14. REMU same operands -> 2.
- DIVU a=123 b=0 -> 0xFFFFFFFF. REM a=-5 b=0 -> 0xFFFFFFFB. DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All complete in 33 cycles.
- Start MUL 3*5; hold start_i=1 with changed operands during CALC -> ignored, result 15. Start a new MUL 2*2 in the FINISH cycle -> accepted; done_o again 33 cycles later with 4.
- Assert rst_i at cycle 10 of a DIV -> busy_o=0, result_o=0, no done_o pulse. A fresh DIVU 9/3 afterwards -> 3.
